// File: rtl/axi_rab_buffer_pkg.sv
// Shared beat layout for the RAB R-channel buffers.
// A beat is {user, data, id, last, resp}, MSB to LSB.
package axi_rab_buffer_pkg;

    localparam int RESP_LSB = 0;
    localparam int RESP_MSB = 1;
    localparam int LAST_BIT = 2;
    localparam int ID_START = 3;

    function automatic int beat_width(input int data_w, input int id_w, input int user_w);
        return user_w + data_w + id_w + 1 + 2;
    endfunction

endpackage

// File: rtl/axi_buffer_fifo_cnt.sv
// Generic register-array FIFO with occupancy count.
// The head entry is read straight from storage, so there is no same-cycle bypass.
module axi_buffer_fifo_cnt #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 8,
    localparam int PTR_W       = $clog2(BUFFER_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_en;
    logic                  pop_en;

    assign full    = (count == CNT_W'(BUFFER_DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop_en)      count <= count + 1'b1;
            else if (pop_en && !push_en) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi4_r_buffer_sf.sv
// AXI4 R-channel buffer for the RAB read path: configurable-depth FIFO with
// optional store-and-forward release of whole bursts.
module axi4_r_buffer_sf
    import axi_rab_buffer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int BUFFER_DEPTH   = 8,
    parameter int STORE_FWD      = 0
) (
    input  logic                             axi4_aclk,
    input  logic                             axi4_arst,
    input  logic [AXI_ID_WIDTH-1:0]          m_axi4_rid,
    input  logic [1:0]                       m_axi4_rresp,
    input  logic [AXI_DATA_WIDTH-1:0]        m_axi4_rdata,
    input  logic                             m_axi4_rlast,
    input  logic [AXI_USER_WIDTH-1:0]        m_axi4_ruser,
    input  logic                             m_axi4_rvalid,
    output logic                             m_axi4_rready,
    output logic [AXI_ID_WIDTH-1:0]          s_axi4_rid,
    output logic [1:0]                       s_axi4_rresp,
    output logic [AXI_DATA_WIDTH-1:0]        s_axi4_rdata,
    output logic                             s_axi4_rlast,
    output logic [AXI_USER_WIDTH-1:0]        s_axi4_ruser,
    output logic                             s_axi4_rvalid,
    input  logic                             s_axi4_rready,
    output logic [$clog2(BUFFER_DEPTH):0]    fill_level,
    output logic                             sf_overflow
);

    localparam int BEAT_W = beat_width(AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);
    localparam int CNT_W  = $clog2(BUFFER_DEPTH) + 1;
    localparam int DATA_START = ID_START + AXI_ID_WIDTH;
    localparam int USER_START = DATA_START + AXI_DATA_WIDTH;

    logic [BEAT_W-1:0] beat_in;
    logic [BEAT_W-1:0] beat_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              push_last;
    logic              pop_last;
    logic              release_ok;
    logic              fwd_open;
    logic [CNT_W-1:0]  burst_cnt;

    assign beat_in = {m_axi4_ruser, m_axi4_rdata, m_axi4_rid, m_axi4_rlast, m_axi4_rresp};

    assign s_axi4_rresp = beat_out[RESP_MSB:RESP_LSB];
    assign s_axi4_rlast = beat_out[LAST_BIT];
    assign s_axi4_rid   = beat_out[ID_START +: AXI_ID_WIDTH];
    assign s_axi4_rdata = beat_out[DATA_START +: AXI_DATA_WIDTH];
    assign s_axi4_ruser = beat_out[USER_START +: AXI_USER_WIDTH];

    axi_buffer_fifo_cnt #(
        .DATA_WIDTH   (BEAT_W),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk   (axi4_aclk),
        .rst   (axi4_arst),
        .push  (push),
        .din   (beat_in),
        .pop   (pop),
        .dout  (beat_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    // Ready comes only from the registered count, never from s_axi4_rready.
    assign m_axi4_rready = ~fifo_full;
    assign push          = m_axi4_rvalid & m_axi4_rready;
    assign pop           = s_axi4_rvalid & s_axi4_rready;
    assign push_last     = push & m_axi4_rlast;
    assign pop_last      = pop & s_axi4_rlast;

    assign release_ok    = (STORE_FWD == 0) || (burst_cnt != '0) || fwd_open;
    assign s_axi4_rvalid = ~fifo_empty & release_ok;

    // A full FIFO with no complete burst can only drain by opening the gate.
    assign sf_overflow = (STORE_FWD != 0) && fifo_full && (burst_cnt == '0) && !fwd_open;

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            burst_cnt <= '0;
            fwd_open  <= 1'b0;
        end else begin
            if (push_last && !pop_last)      burst_cnt <= burst_cnt + 1'b1;
            else if (pop_last && !push_last) burst_cnt <= burst_cnt - 1'b1;

            if (sf_overflow)   fwd_open <= 1'b1;
            else if (pop_last) fwd_open <= 1'b0;
        end
    end

endmodule

// File: doc/axi4_r_buffer_sf.md
Name: axi4_r_buffer_sf

Overview:
Parametrised AXI4 R-channel buffer sitting between the RAB master port (m_*) and the slave-side response path (s_*). It provides a configurable-depth FIFO, an optional store-and-forward mode that holds beats until a complete burst (rlast) has been received, and fill/burst status outputs. It is the successor of the fixed depth-4 cut-through R buffer and drops in at the same position in the RAB read path.

Parameters:
AXI_DATA_WIDTH, 32, R data width
AXI_ID_WIDTH, 4, R ID width
AXI_USER_WIDTH, 4, R user width
BUFFER_DEPTH, 8, FIFO entries; power of two, >= 2
STORE_FWD, 0, 0 = cut-through; 1 = release beats only once a whole burst is buffered

Ports:
axi4_aclk  in  1  clock
axi4_arst  in  1  synchronous active-high reset
m_axi4_rid  in  AXI_ID_WIDTH  upstream R id
m_axi4_rresp  in  2  upstream R resp
m_axi4_rdata  in  AXI_DATA_WIDTH  upstream R data
m_axi4_rlast  in  1  upstream R last
m_axi4_ruser  in  AXI_USER_WIDTH  upstream R user
m_axi4_rvalid  in  1  upstream valid
m_axi4_rready  out  1  ready to upstream
s_axi4_rid  out  AXI_ID_WIDTH  downstream R id
s_axi4_rresp  out  2  downstream R resp
s_axi4_rdata  out  AXI_DATA_WIDTH  downstream R data
s_axi4_rlast  out  1  downstream R last
s_axi4_ruser  out  AXI_USER_WIDTH  downstream R user
s_axi4_rvalid  out  1  downstream valid
s_axi4_rready  in  1  downstream ready
fill_level  out  $clog2(BUFFER_DEPTH)+1  current number of entries
sf_overflow  out  1  one-cycle pulse: store-and-forward forced release

Behaviour:
- Interface: one clock, axi4_aclk; reset axi4_arst is synchronous and active-high.
- Reset (synchronous, active-high): rd/wr pointers = 0, fill_level = 0, burst_cnt = 0, s_axi4_rvalid = 0, m_axi4_rready = 1 in the cycle after reset deasserts, sf_overflow = 0. s_* payload outputs are don't-care while rvalid = 0. Reset mid-burst discards all entries with no draining.
- Beat = {user, data, id, last, resp}, packed in that MSB-to-LSB order.
- Push: m_axi4_rvalid & m_axi4_rready. m_axi4_rready = (fill_level != BUFFER_DEPTH). It depends only on the registered count, with no combinational path from s_axi4_rready.
- Pop: s_axi4_rvalid & s_axi4_rready. Head entry is driven from storage; payload stays stable while valid & !ready.
- Latency: a beat pushed in cycle N is visible on s_* at N+1 at the earliest (cut-through). There is no same-cycle bypass.
- fill_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Pointers wrap modulo BUFFER_DEPTH.
- Full: when fill_level = BUFFER_DEPTH, m_axi4_rready = 0. A simultaneous pop in that cycle does not allow a push in the same cycle.
- Empty: s_axi4_rvalid = 0. A push into an empty FIFO raises rvalid the next cycle.
- STORE_FWD = 0: s_axi4_rvalid = (fill_level != 0).
- STORE_FWD = 1: burst_cnt (width $clog2(BUFFER_DEPTH)+1) counts buffered beats with last = 1.
  - Increments on a push with rlast, decrements on a pop with rlast, unchanged if both happen in the same cycle.
  - s_axi4_rvalid = (fill_level != 0) & (burst_cnt != 0 | fwd_open).
- fwd_open handles bursts longer than BUFFER_DEPTH, which would otherwise deadlock:
  - Set when fill_level = BUFFER_DEPTH and burst_cnt = 0; sf_overflow pulses high for that cycle.
  - Cleared on a pop of a beat with last = 1.
  - While set, beats stream through in cut-through fashion.
- Once s_axi4_rvalid is asserted it is not dropped until the handshake completes; this holds by construction because the release conditions only change on pop.

Decomposition:
- Package axi_rab_buffer_pkg holds:
  - Beat field offset localparams (RESP 1:0, LAST 2, ID_START = 3).
  - A function computing the total beat width from the data/id/user widths.
- One sub-module, axi_buffer_fifo_cnt: a generic DATA_WIDTH x BUFFER_DEPTH FIFO with push/pop, full/empty and a count output.
- The top level adds packing/unpacking, the burst counter, fwd_open, and the valid gating.

Test Plan:
- STORE_FWD=0, DEPTH=8: push 3 beats (data 0xA1, 0xA2, 0xA3, last on the 3rd) with rready=1 -> rvalid rises 1 cycle after the first push; data arrives in order; fill_level peaks at 1.
- STORE_FWD=0: rready=0, push 9 beats -> m_axi4_rready=0 after the 8th push; fill_level=8; rready=1 then drains 8 beats, and the 9th is accepted only the cycle after the first pop.
- STORE_FWD=1, DEPTH=8: push a 4-beat burst with a 1-cycle gap before rlast -> rvalid stays 0 until the cycle after the rlast push, then 4 beats pop back-to-back with id/user preserved.
- STORE_FWD=1, DEPTH=4: 6-beat burst, rready=1 -> sf_overflow pulses once when fill_level=4; all 6 beats are delivered; rvalid gating resumes for the next burst.
- STORE_FWD=1: simultaneous pop of last burst A and push of last burst B -> burst_cnt unchanged at 1; B is released without a bubble.
- Assert axi4_arst with fill_level=5 mid-burst -> next cycle: fill_level=0, s_axi4_rvalid=0, burst_cnt=0; a subsequent 2-beat burst is delivered correctly.
